// File: rtl/song_sequencer_if.sv
// song_sequencer_if: button-controller inputs, song ROM port and tone-generator outputs of the sequencer
interface song_sequencer_if #(parameter int IDX_W = 6);
  logic             enable;
  logic [1:0]       song_num;
  logic             pause;
  logic [IDX_W+1:0] rom_addr;
  logic [7:0]       rom_data;
  logic [4:0]       note;
  logic             playing;
  logic             song_done;
  modport master (
    input  enable, song_num, pause, rom_data,
    output rom_addr, note, playing, song_done
  );
  modport slave (
    output enable, song_num, pause, rom_data,
    input  rom_addr, note, playing, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: steps through ROM note records, holding each note for its duration followed by a silent gap
module song_sequencer #(
  parameter int IDX_W          = 6,
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 2_000_000,
  parameter bit LOOP           = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  song_sequencer_if.master bus
);
  localparam int MAX_T = 7 * TICKS_PER_BEAT > GAP_TICKS ? 7 * TICKS_PER_BEAT : GAP_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] TPB      = CNT_W'(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [1:0]       song, song_n;
  logic [4:0]       code, code_n;
  logic [2:0]       dur;
  logic             swap;
  assign dur  = bus.rom_data[7:5];
  assign swap = state != IDLE && bus.song_num != song;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      song  <= '0;
      code  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      song  <= song_n;
      code  <= code_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    song_n  = song;
    code_n  = code;
    if (!bus.enable)
      state_n = IDLE;
    else if (state == IDLE || swap) begin
      state_n = FETCH;
      song_n  = bus.song_num;
      idx_n   = '0;
    end else
      case (state)
        FETCH: state_n = LOAD;
        LOAD:
          if (dur == '0)
            state_n = DONE;
          else begin
            state_n = PLAY;
            code_n  = bus.rom_data[4:0];
            cnt_n   = CNT_W'(dur) * TPB - 1'b1;
          end
        PLAY:
          if (!bus.pause) begin
            state_n = cnt == '0 ? GAP : PLAY;
            cnt_n   = cnt == '0 ? GAP_LAST : cnt - 1'b1;
          end
        GAP:
          if (!bus.pause) begin
            state_n = cnt != '0 ? GAP : &idx ? DONE : FETCH;
            cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
            idx_n   = cnt == '0 && !(&idx) ? idx + 1'b1 : idx;
          end
        DONE:
          if (LOOP) begin
            state_n = FETCH;
            idx_n   = '0;
          end
        default: state_n = IDLE;
      endcase
  end
  assign bus.rom_addr  = {song, idx};
  assign bus.note      = state == PLAY && !bus.pause && bus.enable && !swap ? code : '0;
  assign bus.playing   = (state == FETCH || state == LOAD || state == PLAY || state == GAP) && !bus.pause;
  assign bus.song_done = state_n == DONE && state != DONE;
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Auto-play sequencer that steps through a song stored in an external synchronous ROM.
- Fetches one note record at a time and holds its note code on the tone-generator input for the encoded duration, then inserts an articulation gap.
- Honours the song selection and pause signals produced by the button logic.
- Sits between the button controller and the tone/speaker datapath inside the main controller; it is active only in auto mode.

Parameters:
- IDX_W, 6, note index width; a song holds at most 2^IDX_W records.
- TICKS_PER_BEAT, 25_000_000, clk cycles per duration unit (0.25 s at 100 MHz).
- GAP_TICKS, 2_000_000, silent clk cycles between consecutive notes.
- LOOP, 1, 1 = restart the song after its end; 0 = hold in DONE.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset).
- enable  in  1  1 while mode selects auto play.
- song_num  in  2  selected song.
- pause  in  1  level; 1 freezes playback.
- rom_addr  out  IDX_W+2  {song_num_latched, index}.
- rom_data  in  8  [7:5] duration in beats (0 = end marker), [4:0] note code (0 = rest).
- note  out  5  note code to the tone generator; 0 = silence.
- playing  out  1  1 in FETCH/LOAD/PLAY/GAP while not paused.
- song_done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset: state IDLE, index 0, rom_addr 0, note 0, playing 0, song_done 0, all counters 0.
- State sequence:
  - IDLE: on enable=1, latch song_num, index=0, go to FETCH.
  - FETCH (1 cycle): rom_addr = {latched song, index}.
  - LOAD (1 cycle): sample rom_data. If duration = 0, go to DONE. Otherwise store duration and note, set counter = duration*TICKS_PER_BEAT-1, go to PLAY.
  - PLAY: note = stored code. Counter decrements each cycle; at 0, go to GAP with counter = GAP_TICKS-1.
  - GAP: note = 0. At 0, index+1 and go to FETCH.
  - DONE: note = 0, song_done pulses on entry. If LOOP=1, index=0 and go to FETCH next cycle; otherwise hold.
- Note-to-note period = 2 + dur*TICKS_PER_BEAT + GAP_TICKS cycles. The first note appears on the 3rd cycle after enable is sampled high.
- Index wrap: if index = all-ones and GAP completes, treat it as the end of the song and go to DONE; the index never wraps silently.
- Multiplier width: duration*TICKS_PER_BEAT is computed in a counter wide enough for 7*TICKS_PER_BEAT.
- Pause = 1:
  - In PLAY/GAP: counters freeze, note forced 0, playing 0, state is retained.
  - In FETCH/LOAD: the current step completes, then the block freezes before PLAY.
  - Pause falling: resume with the remaining count; no refetch.
- song_num differs from the latched value in any non-IDLE state: abort, latch the new song, index=0, note=0 that cycle, FETCH next cycle. This takes priority over pause.
- enable = 0: return to IDLE on the next clk, note = 0. It has priority over everything except reset.
- Simultaneous end of GAP and song change: the song change wins.
- Reset mid-note: note drops to 0 asynchronously.

Test Plan:
- TICKS_PER_BEAT=4, GAP_TICKS=2, ROM song0 = {dur1 note5, dur2 note3, end}; enable rises at cycle 0 -> note=5 for cycles 3-6, 0 for 7-8, note=3 for cycles 11-18, song_done pulse at cycle 22.
- Same ROM, pause=1 for 10 cycles starting at cycle 5 -> note=0 and playing=0 during the pause; note=5 resumes for the remaining 2 cycles, then timing continues shifted by 10.
- song_num changes 0->2 during PLAY of song0 -> next cycle note=0, rom_addr = {2,0} one cycle later, song2 first note 3 cycles after the change.
- LOOP=0, end reached -> note held 0, single song_done pulse; LOOP=1 -> rom_addr returns to {song,0} on the cycle after DONE.
- enable dropped mid-note, then rst_n pulsed high asynchronously mid-GAP -> IDLE, note=0 immediately on reset, all outputs at reset values.
- ROM filled with 64 nonzero records (IDX_W=6) -> after index 63 the block enters DONE, with no read at index 0 before song_done.
